acq_sequencer: RTL and testbench
================================

// Module: acq_sequencer
// PURPOSE
//  Acquisition controller behind the data_in front-end.
//  Selects one source: simulated data, HS ADC channel A, HS ADC channel B, or ADC 2308.
//  Arms on a start command, optionally waits for a trigger such as a DAC cycle-start pulse, then captures n_ciclos*ptos_x_ciclo samples.
//  Forwards the captured samples as a framed valid/ready stream to the processing chain.
//  All source interfaces are already in the clk domain.
// PARAMETERS
//  DATA_W  32  output sample width; 14-bit ADC words are zero-extended to this width
//  CNT_W   32  width of the point, cycle and sample counters
// PORTS
//  clk           in   1       single block clock, rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  start         in   1       1-cycle pulse: latch config, begin acquisition
//  abort         in   1       1-cycle pulse: return to IDLE from any state
//  src_sel       in   2       0=sim 1=adc_a 2=adc_b 3=adc_2308
//  trig_mode     in   1       0=capture immediately, 1=wait for trig_in
//  trig_in       in   1       trigger pulse (e.g. DAC cycle start)
//  ptos_x_ciclo  in   CNT_W   samples per cycle
//  n_ciclos      in   CNT_W   cycles per acquisition
//  sim_data      in   32      simulated sample; sim_valid in 1 qualifies it
//  adc_a/adc_b   in   14      HS ADC samples; adc_valid in 1 qualifies both
//  adc2308_data  in   32      ADC 2308 sample; adc2308_valid in 1 qualifies it
//  out_data      out  DATA_W  captured sample
//  out_valid     out  1       out_data valid
//  out_ready     in   1       downstream accepts when out_valid&&out_ready
//  out_sop       out  1       first sample of the frame (qualified by out_valid)
//  out_eop       out  1       last sample of the frame (qualified by out_valid)
//  busy          out  1       high in ARM or CAPTURE
//  done          out  1       1-cycle pulse when the frame completes
//  overrun       out  1       sticky: a sample was dropped because the output was stalled
//  sample_count  out  CNT_W   samples delivered into the output register this frame
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0 and every counter is 0.
//  FSM states: IDLE, ARM, CAPTURE, DONE.
//   IDLE --start--> ARM when trig_mode=1; CAPTURE when trig_mode=0.
//    If ptos_x_ciclo==0 or n_ciclos==0, start goes directly to DONE; no samples are emitted.
//   ARM --trig_in--> CAPTURE. Samples arriving in the same cycle as trig_in are not captured.
//   CAPTURE --> DONE on acceptance into the output register of the last sample:
//    pt_cnt==ptos_x_ciclo-1 and cyc_cnt==n_ciclos-1.
//   DONE: done=1 for exactly one cycle, then IDLE.
//   abort in any state: go to IDLE next cycle, clear out_valid, no done pulse. abort has priority over start.
//  start is ignored unless state==IDLE. On start, the block:
//   - latches src_sel, trig_mode, ptos_x_ciclo and n_ciclos;
//   - clears the counters, sample_count and overrun.
//  Selected sample: the source's valid bit gates it. adc_a and adc_b are zero-extended to DATA_W.
//  Capture (CAPTURE state, selected valid=1):
//   - If out_valid==0 or out_ready==1: load out_data at the next edge (1-cycle latency) and set out_valid.
//     Also set out_sop when pt_cnt==0 and cyc_cnt==0, set out_eop on the last sample,
//     advance pt_cnt (wrapping at ptos_x_ciclo-1, with cyc_cnt+1 on wrap) and increment sample_count.
//   - Else (output stalled): drop the sample, set overrun=1, and do not advance the counters.
//  Output handshake:
//   - out_valid clears when out_valid&&out_ready and no new sample loads in the same cycle.
//   - A simultaneous accept and load keeps out_valid=1 with the new data.
//   - out_data, out_sop and out_eop stay stable while out_valid&&!out_ready.
//   - The final sample may still be pending in DONE or IDLE. It is held until accepted; abort discards it.
//  Counter arithmetic is unsigned CNT_W. The frame length is not multiplied; it is tracked by nested counters.
// TESTING
//  1. sim source, trig_mode=0, ptos=4, ciclos=2, sim_valid=1 every cycle, out_ready=1
//     -> 8 samples; sop on the 1st, eop on the 8th; done pulses once; sample_count=8.
//  2. trig_mode=1, adc_a, adc_valid=1 always, trig_in pulse at cycle 20
//     -> no out_valid before cycle 21; first sample = adc_a value at cycle 21, zero-extended.
//  3. out_ready=0 for 3 cycles mid-frame, with source valid every cycle
//     -> out_data held; overrun=1; the 3 dropped samples are not counted; frame still totals ptos*ciclos samples.
//  4. abort during CAPTURE at sample 5 of 16
//     -> IDLE next cycle; out_valid=0; no done; busy=0. A new start restarts with sample_count=0.
//  5. start with n_ciclos=0 -> done pulse 1 cycle after start; out_valid never asserts.
//     start while busy -> ignored; config unchanged.
//  6. reset_n asserted mid-CAPTURE (asynchronous, between edges)
//     -> all outputs 0 immediately; after release, IDLE; start works normally.

Source files
------------

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arm on start, optional trigger wait, capture a framed burst of samples from one selected source.
// One-cycle source-to-output latency; samples arriving while the output register is stalled are dropped and flagged.
module acq_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        src_sel,
    input  logic              trig_mode,
    input  logic              trig_in,
    input  logic [CNT_W-1:0]  ptos_x_ciclo,
    input  logic [CNT_W-1:0]  n_ciclos,
    input  logic [31:0]       sim_data,
    input  logic              sim_valid,
    input  logic [13:0]       adc_a,
    input  logic [13:0]       adc_b,
    input  logic              adc_valid,
    input  logic [31:0]       adc2308_data,
    input  logic              adc2308_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [CNT_W-1:0]  sample_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          src_q, src_d;
    logic                trig_mode_q, trig_mode_d;
    logic [CNT_W-1:0]    ptos_q, ptos_d;
    logic [CNT_W-1:0]    ncyc_q, ncyc_d;
    logic [CNT_W-1:0]    pt_cnt_q, pt_cnt_d;
    logic [CNT_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]    sample_count_q, sample_count_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic [DATA_W-1:0]   sel_dat;
    logic                sel_vld;
    logic                can_load;
    logic                pt_wrap;
    logic                is_last;

    always_comb begin
        sel_dat = '0;
        sel_vld = 1'b0;
        unique case (src_q)
            2'd0: begin sel_dat = DATA_W'(sim_data);     sel_vld = sim_valid;     end
            2'd1: begin sel_dat = DATA_W'(adc_a);        sel_vld = adc_valid;     end
            2'd2: begin sel_dat = DATA_W'(adc_b);        sel_vld = adc_valid;     end
            default: begin sel_dat = DATA_W'(adc2308_data); sel_vld = adc2308_valid; end
        endcase
    end

    // The output register can take a new sample if empty or draining this cycle.
    assign can_load = !out_valid_q || out_ready;
    assign pt_wrap  = (pt_cnt_q == ptos_q - CNT_W'(1));
    assign is_last  = pt_wrap && (cyc_cnt_q == ncyc_q - CNT_W'(1));

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        trig_mode_d    = trig_mode_q;
        ptos_d         = ptos_q;
        ncyc_d         = ncyc_q;
        pt_cnt_d       = pt_cnt_q;
        cyc_cnt_d      = cyc_cnt_q;
        sample_count_d = sample_count_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_sop_d      = out_sop_q;
        out_eop_d      = out_eop_q;
        overrun_d      = overrun_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_d          = src_sel;
                        trig_mode_d    = trig_mode;
                        ptos_d         = ptos_x_ciclo;
                        ncyc_d         = n_ciclos;
                        pt_cnt_d       = '0;
                        cyc_cnt_d      = '0;
                        sample_count_d = '0;
                        overrun_d      = 1'b0;
                        if (ptos_x_ciclo == '0 || n_ciclos == '0) begin
                            state_d = ST_DONE;
                        end else if (trig_mode) begin
                            state_d = ST_ARM;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_ARM: begin
                    if (trig_in) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sel_vld) begin
                        if (can_load) begin
                            out_data_d     = sel_dat;
                            out_valid_d    = 1'b1;
                            out_sop_d      = (pt_cnt_q == '0) && (cyc_cnt_q == '0);
                            out_eop_d      = is_last;
                            sample_count_d = sample_count_q + CNT_W'(1);
                            if (is_last) begin
                                state_d = ST_DONE;
                            end else if (pt_wrap) begin
                                pt_cnt_d  = '0;
                                cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                            end else begin
                                pt_cnt_d = pt_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            src_q          <= '0;
            trig_mode_q    <= 1'b0;
            ptos_q         <= '0;
            ncyc_q         <= '0;
            pt_cnt_q       <= '0;
            cyc_cnt_q      <= '0;
            sample_count_q <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_sop_q      <= 1'b0;
            out_eop_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            trig_mode_q    <= trig_mode_d;
            ptos_q         <= ptos_d;
            ncyc_q         <= ncyc_d;
            pt_cnt_q       <= pt_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            sample_count_q <= sample_count_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_sop_q      <= out_sop_d;
            out_eop_q      <= out_eop_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_sop      = out_sop_q;
    assign out_eop      = out_eop_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign sample_count = sample_count_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: expected beats queued as stimulus is driven, checked as the output handshakes.
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic [1:0]  src_sel;
    logic        trig_mode, trig_in;
    logic [31:0] ptos_x_ciclo, n_ciclos;
    logic [31:0] sim_data;
    logic        sim_valid;
    logic [13:0] adc_a, adc_b;
    logic        adc_valid;
    logic [31:0] adc2308_data;
    logic        adc2308_valid;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_sop, out_eop;
    logic        busy, done, overrun;
    logic [31:0] sample_count;

    typedef struct packed {
        logic [31:0] dat;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    int   d0;

    acq_sequencer #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .src_sel(src_sel), .trig_mode(trig_mode), .trig_in(trig_in),
        .ptos_x_ciclo(ptos_x_ciclo), .n_ciclos(n_ciclos),
        .sim_data(sim_data), .sim_valid(sim_valid),
        .adc_a(adc_a), .adc_b(adc_b), .adc_valid(adc_valid),
        .adc2308_data(adc2308_data), .adc2308_valid(adc2308_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .done(done),
        .overrun(overrun), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic s, input logic e);
        exp_t x;
        x.dat = d;
        x.sop = s;
        x.eop = e;
        sb.push_back(x);
    endtask

    task automatic do_start(input logic [1:0] s, input logic tm, input logic [31:0] p, input logic [31:0] n);
        src_sel      = s;
        trig_mode    = tm;
        ptos_x_ciclo = p;
        n_ciclos     = n;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    // Every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t x;
        if (done === 1'b1) done_seen++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("beat_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("beat_data", out_data, x.dat);
                chk("beat_sop", out_sop, x.sop);
                chk("beat_eop", out_eop, x.eop);
            end
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; src_sel = 2'd0;
        trig_mode = 1'b0; trig_in = 1'b0; ptos_x_ciclo = '0; n_ciclos = '0;
        sim_data = '0; sim_valid = 1'b0; adc_a = '0; adc_b = '0; adc_valid = 1'b0;
        adc2308_data = 32'hA5A5_0000; adc2308_valid = 1'b1; out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_data", out_data, 0);
        reset_n = 1'b1;
        step();

        // 1: immediate capture, 4 x 2 frame
        sim_valid = 1'b1;
        out_ready = 1'b1;
        d0 = done_seen;
        do_start(2'd0, 1'b0, 4, 2);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            sim_data = 32'h1000 + i;
            push(sim_data, i == 0, i == 7);
            step();
        end
        chk("t1_done", done, 1);
        chk("t1_count", sample_count, 8);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_idle", busy, 0);
        step();
        chk("t1_done_once", done_seen - d0, 1);
        chk("t1_drained", sb.size(), 0);

        // 2: triggered capture from adc_a, zero-extended
        sim_data  = 32'hFFFF_FFFF;
        adc_b     = 14'h1555;
        adc_valid = 1'b1;
        do_start(2'd1, 1'b1, 3, 1);
        chk("t2_busy_arm", busy, 1);
        for (int c = 0; c < 18; c++) begin
            adc_a = 14'(c + 1);
            step();
            chk("t2_no_valid_arm", out_valid, 0);
        end
        trig_in = 1'b1;
        adc_a   = 14'h2222;
        step();
        trig_in = 1'b0;
        chk("t2_no_valid_trig", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            adc_a = 14'h3F00 + 14'(i);
            push({18'd0, adc_a}, i == 0, i == 2);
            step();
        end
        chk("t2_done", done, 1);
        step();
        step();
        chk("t2_drained", sb.size(), 0);

        // 3: three-cycle output stall mid-frame
        do_start(2'd0, 1'b0, 4, 2);
        for (int i = 0; i < 3; i++) begin
            sim_data = 32'h3000 + i;
            push(sim_data, i == 0, 1'b0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b0;
            sim_data  = 32'hBAD0 + k;
            step();
            chk("t3_hold_data", out_data, 32'h3002);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_sop", out_sop, 0);
        end
        chk("t3_overrun", overrun, 1);
        chk("t3_count_stall", sample_count, 3);
        out_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            sim_data = 32'h3000 + i;
            push(sim_data, 1'b0, i == 7);
            step();
        end
        chk("t3_done", done, 1);
        chk("t3_count", sample_count, 8);
        step();
        step();
        chk("t3_drained", sb.size(), 0);

        // 4: abort at sample 5 of 16, then restart
        do_start(2'd0, 1'b0, 8, 2);
        chk("t4_overrun_clr", overrun, 0);
        for (int i = 0; i < 4; i++) begin
            sim_data = 32'h4000 + i;
            push(sim_data, i == 0, 1'b0);
            step();
        end
        abort    = 1'b1;
        sim_data = 32'h4444;
        step();
        abort = 1'b0;
        chk("t4_valid", out_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        d0 = done_seen;
        step();
        step();
        step();
        chk("t4_no_done", done_seen - d0, 0);
        chk("t4_drained", sb.size(), 0);
        do_start(2'd0, 1'b0, 2, 1);
        chk("t4_count_restart", sample_count, 0);
        for (int i = 0; i < 2; i++) begin
            sim_data = 32'h4100 + i;
            push(sim_data, i == 0, i == 1);
            step();
        end
        chk("t4_restart_done", done, 1);
        step();
        step();

        // 5: zero-length frame, then start while busy
        do_start(2'd0, 1'b0, 4, 0);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_valid", out_valid, 0);
        chk("t5_zero_busy", busy, 0);
        step();
        chk("t5_zero_done_end", done, 0);
        chk("t5_zero_valid_end", out_valid, 0);
        do_start(2'd0, 1'b0, 2, 2);
        sim_data = 32'h5000;
        push(sim_data, 1'b1, 1'b0);
        step();
        src_sel      = 2'd2;
        ptos_x_ciclo = 9;
        n_ciclos     = 9;
        start        = 1'b1;
        sim_data     = 32'h5001;
        push(sim_data, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int i = 2; i < 4; i++) begin
            sim_data = 32'h5000 + i;
            push(sim_data, 1'b0, i == 3);
            step();
        end
        chk("t5_busy_start_done", done, 1);
        chk("t5_busy_start_count", sample_count, 4);
        step();
        step();
        chk("t5_drained", sb.size(), 0);

        // 6: asynchronous reset mid-capture
        do_start(2'd0, 1'b0, 4, 2);
        for (int i = 0; i < 2; i++) begin
            sim_data = 32'h6000 + i;
            push(sim_data, i == 0, 1'b0);
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_count", sample_count, 0);
        chk("t6_data", out_data, 0);
        chk("t6_sop", out_sop, 0);
        sb.delete();
        reset_n = 1'b1;
        step();
        chk("t6_idle", busy, 0);
        do_start(2'd0, 1'b0, 2, 1);
        chk("t6_restart_busy", busy, 1);
        for (int i = 0; i < 2; i++) begin
            sim_data = 32'h6100 + i;
            push(sim_data, i == 0, i == 1);
            step();
        end
        chk("t6_restart_done", done, 1);
        chk("t6_restart_count", sample_count, 2);
        step();
        step();
        chk("t6_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
